// File: rtl/logic_pipe_pkg.sv
// rtl/logic_pipe_pkg.sv - op encoding and per-bit direct/dual-form gate functions
package logic_pipe_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND   = 3'd0;
  localparam op_t OP_NAND  = 3'd1;
  localparam op_t OP_OR    = 3'd2;
  localparam op_t OP_NOR   = 3'd3;
  localparam op_t OP_NANB  = 3'd4;
  localparam op_t OP_NAONB = 3'd5;
  localparam op_t OP_XOR   = 3'd6;
  localparam op_t OP_PASSA = 3'd7;

  // Bitwise ops are applied one bit at a time so the functions stay width-agnostic.
  function automatic logic direct_bit(op_t op, logic a, logic b);
    case (op)
      OP_AND:   return a & b;
      OP_NAND:  return ~(a & b);
      OP_OR:    return a | b;
      OP_NOR:   return ~(a | b);
      OP_NANB:  return ~a & ~b;
      OP_NAONB: return ~a | ~b;
      OP_XOR:   return a ^ b;
      default:  return a;
    endcase
  endfunction

  function automatic logic dual_bit(op_t op, logic a, logic b);
    case (op)
      OP_AND:   return ~(~a | ~b);
      OP_NAND:  return ~a | ~b;
      OP_OR:    return ~(~a & ~b);
      OP_NOR:   return ~a & ~b;
      OP_NANB:  return ~(a | b);
      OP_NAONB: return ~(a & b);
      OP_XOR:   return (a & ~b) | (~a & b);
      default:  return ~(~a);
    endcase
  endfunction

endpackage

// File: rtl/logic_pipe_dual_check_compare.sv
// rtl/logic_pipe_dual_check_compare.sv - combinational direct vs dual-form compare
module dual_form_compare
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flt_i,
  output logic [WIDTH-1:0] direct_o,
  output logic             mis_o
);

  logic [WIDTH-1:0] dual;

  always_comb begin
    direct_o = '0;
    dual     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      direct_o[i] = direct_bit(op_i, a_i[i], b_i[i]);
      dual[i]     = dual_bit(op_i, a_i[i], b_i[i]);
    end
    dual[0] = dual[0] ^ flt_i;
    mis_o   = |(direct_o ^ dual);
  end

endmodule

// File: rtl/logic_pipe_dual_check.sv
// rtl/logic_pipe_dual_check.sv - elastic one-stage self-checking logic pipe with error counter
module logic_pipe_dual_check
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  op_t                  in_op,
  input  logic                 in_flt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_y,
  output logic                 out_mis,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  logic                 valid_q, mis_q, sticky_q, sticky_d;
  logic [WIDTH-1:0]     y_q;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [WIDTH-1:0]     direct_c;
  logic                 mis_c, accept;

  dual_form_compare #(.WIDTH(WIDTH)) u_cmp (
    .op_i    (in_op),
    .a_i     (in_a),
    .b_i     (in_b),
    .flt_i   (in_flt),
    .direct_o(direct_c),
    .mis_o   (mis_c)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Clear takes effect before the count of a beat accepted in the same cycle.
  always_comb begin
    cnt_base = err_clr ? '0 : cnt_q;
    cnt_d    = cnt_base;
    sticky_d = err_clr ? 1'b0 : sticky_q;
    if (accept && mis_c) begin
      sticky_d = 1'b1;
      if (cnt_base != '1) cnt_d = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      y_q      <= '0;
      mis_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        y_q     <= direct_c;
        mis_q   <= mis_c;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_y      = y_q;
  assign out_mis    = mis_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_logic_pipe_dual_check.sv
// tb/tb_logic_pipe_dual_check.sv - directed table-driven bench for logic_pipe_dual_check
module tb_logic_pipe_dual_check;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_flt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_mis;
  logic       err_sticky;
  logic [1:0] err_cnt;
  logic       err_clr;

  int checks   = 0;
  int failures = 0;

  logic_pipe_dual_check #(.WIDTH(8), .ERR_CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_flt    (in_flt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_mis   (out_mis),
    .err_sticky(err_sticky),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{3'd0, 8'hA5, 8'h3C, 8'h24};
    vecs[1] = '{3'd1, 8'hA5, 8'h3C, 8'hDB};
    vecs[2] = '{3'd2, 8'hA5, 8'h3C, 8'hBD};
    vecs[3] = '{3'd3, 8'hA5, 8'h3C, 8'h42};
    vecs[4] = '{3'd4, 8'hA5, 8'h3C, 8'h42};
    vecs[5] = '{3'd5, 8'hA5, 8'h3C, 8'hDB};
    vecs[6] = '{3'd6, 8'hA5, 8'h3C, 8'h99};
    vecs[7] = '{3'd7, 8'hA5, 8'h3C, 8'hA5};
    vecs[8] = '{3'd6, 8'hFF, 8'h0F, 8'hF0};
    vecs[9] = '{3'd3, 8'h00, 8'h00, 8'hFF};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_flt = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_mis", 32'(out_mis), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // One beat per cycle; each result is checked one edge after its beat.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_y", i), 32'(out_y), 32'(vecs[i].exp_y));
      chk($sformatf("vec%0d_mis", i), 32'(out_mis), 32'd0);
    end
    in_valid = 1'b0;
    in_op = 3'bxxx;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_y_hold", 32'(out_y), 32'hFF);
    chk("table_err_cnt", 32'(err_cnt), 32'd0);
    chk("table_sticky", 32'(err_sticky), 32'd0);

    // Backpressure
    in_valid = 1'b1; in_op = 3'd0; in_a = 8'hF0; in_b = 8'h3C;
    step();
    chk("bp_first_y", 32'(out_y), 32'h30);
    out_ready = 1'b0; in_op = 3'd2; in_a = 8'hF0; in_b = 8'h0F;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_y", k), 32'(out_y), 32'h30);
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", 32'(in_ready), 32'd1);
    step();
    chk("bp_queued_y", 32'(out_y), 32'hFF);
    chk("bp_queued_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_drain_valid", 32'(out_valid), 32'd0);

    // Fault injection and counter saturation (2-bit counter)
    in_valid = 1'b1; in_op = 3'd0; in_a = 8'hFF; in_b = 8'h0F; in_flt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("flt%0d_y", k), 32'(out_y), 32'h0F);
      chk($sformatf("flt%0d_mis", k), 32'(out_mis), 32'd1);
      chk($sformatf("flt%0d_sticky", k), 32'(err_sticky), 32'd1);
      chk($sformatf("flt%0d_cnt", k), 32'(err_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    err_clr = 1'b1;
    step();
    chk("clr_beat_cnt", 32'(err_cnt), 32'd1);
    chk("clr_beat_sticky", 32'(err_sticky), 32'd1);

    // Clear alone, output held by backpressure
    in_valid = 1'b0; in_flt = 1'b0; out_ready = 1'b0;
    step();
    chk("clr_cnt", 32'(err_cnt), 32'd0);
    chk("clr_sticky", 32'(err_sticky), 32'd0);
    chk("clr_out_valid", 32'(out_valid), 32'd1);
    chk("clr_out_y", 32'(out_y), 32'h0F);
    err_clr = 1'b0;

    // Mid-stream reset with a held result and an offered faulted beat
    out_ready = 1'b1; in_valid = 1'b1; in_flt = 1'b1;
    step();
    chk("pre_rst_cnt", 32'(err_cnt), 32'd1);
    reset = 1'b1;
    step(); step();
    reset = 1'b0; in_valid = 1'b0; in_flt = 1'b0;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_y", 32'(out_y), 32'd0);
    chk("mrst_out_mis", 32'(out_mis), 32'd0);
    chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mrst_err_sticky", 32'(err_sticky), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
